// File: rtl/grid_paint_ctrl_if.sv
// Command and grid-write bundle for grid_paint_ctrl. The requester (game logic or a
// bench) takes the master side; the controller takes the slave side.
interface grid_paint_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_cmd;
    logic [3:0] req_x;
    logic [3:0] req_y;
    logic [2:0] req_color;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] posX;
    logic [3:0] posY;
    logic       wr_enable;
    logic [7:0] r_out;
    logic [7:0] g_out;
    logic [7:0] b_out;

    modport master (
        output req_valid, req_cmd, req_x, req_y, req_color,
        input  req_ready, busy, done, err, posX, posY, wr_enable, r_out, g_out, b_out
    );

    modport slave (
        input  req_valid, req_cmd, req_x, req_y, req_color,
        output req_ready, busy, done, err, posX, posY, wr_enable, r_out, g_out, b_out
    );
endinterface

// File: rtl/grid_paint_ctrl.sv
// Write-side controller for the VGA colour grid: expands paint/row/column/clear commands
// into one-cycle cell writes. Define GRID_PAINT_CLEAR_ON_RESET_EN to sweep the grid after reset.
module grid_paint_ctrl #(
    parameter int GRID_W = 8,
    parameter int GRID_H = 8
) (
    input  logic              clk,
    input  logic              rst,
    grid_paint_ctrl_if.slave  bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PAINT = 3'd1;
    localparam logic [2:0] S_ROW   = 3'd2;
    localparam logic [2:0] S_COL   = 3'd3;
    localparam logic [2:0] S_CLEAR = 3'd4;

    localparam logic [1:0] CMD_PAINT = 2'b00;
    localparam logic [1:0] CMD_CLEAR = 2'b01;
    localparam logic [1:0] CMD_ROW   = 2'b10;
    localparam logic [1:0] CMD_COL   = 2'b11;

    localparam logic [3:0] X_LAST = 4'(GRID_W - 1);
    localparam logic [3:0] Y_LAST = 4'(GRID_H - 1);
    localparam logic [4:0] W_LIM  = 5'(GRID_W);
    localparam logic [4:0] H_LIM  = 5'(GRID_H);

    function automatic logic [23:0] palette(input logic [2:0] idx);
        logic [23:0] rgb;
        case (idx)
            3'd0:    rgb = 24'h53565B;
            3'd1:    rgb = 24'hFFFFFF;
            3'd2:    rgb = 24'h000000;
            3'd3:    rgb = 24'hE03030;
            3'd4:    rgb = 24'h30C040;
            3'd5:    rgb = 24'h3060E0;
            3'd6:    rgb = 24'hF0D020;
            default: rgb = 24'hD9D9D6;
        endcase
        return rgb;
    endfunction

    logic [2:0]  state_q, state_d;
    logic [3:0]  posx_q, posx_d;
    logic [3:0]  posy_q, posy_d;
    logic        wr_q, wr_d;
    logic [23:0] rgb_q, rgb_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        accept;
    logic        x_ok;
    logic        y_ok;
    logic        cmd_ok;
    logic        first_last;
    logic [2:0]  cmd_state;
    logic [3:0]  first_x;
    logic [3:0]  first_y;
    logic [3:0]  next_x;
    logic [3:0]  next_y;
    logic        start_clear;

`ifdef GRID_PAINT_CLEAR_ON_RESET_EN
    logic init_q;
    assign start_clear = init_q;
`else
    assign start_clear = 1'b0;
`endif

    assign accept = bus.req_valid && (state_q == S_IDLE);
    assign x_ok   = ({1'b0, bus.req_x} < W_LIM);
    assign y_ok   = ({1'b0, bus.req_y} < H_LIM);

    // Decode of an incoming command: legality, target state and the first cell written
    always_comb begin
        cmd_ok     = 1'b1;
        cmd_state  = S_PAINT;
        first_x    = bus.req_x;
        first_y    = bus.req_y;
        first_last = 1'b1;
        case (bus.req_cmd)
            CMD_PAINT: begin
                cmd_ok = x_ok && y_ok;
            end
            CMD_CLEAR: begin
                cmd_state  = S_CLEAR;
                first_x    = 4'd0;
                first_y    = 4'd0;
                first_last = (X_LAST == 4'd0) && (Y_LAST == 4'd0);
            end
            CMD_ROW: begin
                cmd_ok     = y_ok;
                cmd_state  = S_ROW;
                first_x    = 4'd0;
                first_last = (X_LAST == 4'd0);
            end
            default: begin
                cmd_ok     = x_ok;
                cmd_state  = S_COL;
                first_y    = 4'd0;
                first_last = (Y_LAST == 4'd0);
            end
        endcase
    end

    // Walk order inside a sequence; clear is row-major with x fastest
    always_comb begin
        next_x = posx_q;
        next_y = posy_q;
        case (state_q)
            S_ROW:   next_x = posx_q + 4'd1;
            S_COL:   next_y = posy_q + 4'd1;
            S_CLEAR: begin
                if (posx_q == X_LAST) begin
                    next_x = 4'd0;
                    next_y = posy_q + 4'd1;
                end else begin
                    next_x = posx_q + 4'd1;
                end
            end
            default: begin
                next_x = posx_q;
                next_y = posy_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        posx_d  = posx_q;
        posy_d  = posy_q;
        wr_d    = 1'b0;
        rgb_d   = rgb_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (start_clear) begin
            state_d = S_CLEAR;
            posx_d  = 4'd0;
            posy_d  = 4'd0;
            wr_d    = 1'b1;
            rgb_d   = palette(3'd0);
            busy_d  = 1'b1;
            done_d  = (X_LAST == 4'd0) && (Y_LAST == 4'd0);
        end else if (state_q == S_IDLE) begin
            if (accept) begin
                if (cmd_ok) begin
                    state_d = cmd_state;
                    posx_d  = first_x;
                    posy_d  = first_y;
                    wr_d    = 1'b1;
                    rgb_d   = palette((bus.req_cmd == CMD_CLEAR) ? 3'd0 : bus.req_color);
                    busy_d  = 1'b1;
                    done_d  = first_last;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (done_q || (state_q == S_PAINT)) begin
            state_d = S_IDLE;
        end else begin
            posx_d = next_x;
            posy_d = next_y;
            wr_d   = 1'b1;
            busy_d = 1'b1;
            case (state_q)
                S_ROW:   done_d = (next_x == X_LAST);
                S_COL:   done_d = (next_y == Y_LAST);
                default: done_d = (next_x == X_LAST) && (next_y == Y_LAST);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef GRID_PAINT_CLEAR_ON_RESET_EN
            state_q <= S_CLEAR;
            init_q  <= 1'b1;
`else
            state_q <= S_IDLE;
`endif
            posx_q  <= 4'd0;
            posy_q  <= 4'd0;
            wr_q    <= 1'b0;
            rgb_q   <= 24'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
`ifdef GRID_PAINT_CLEAR_ON_RESET_EN
            init_q  <= 1'b0;
`endif
            state_q <= state_d;
            posx_q  <= posx_d;
            posy_q  <= posy_d;
            wr_q    <= wr_d;
            rgb_q   <= rgb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.posX      = posx_q;
    assign bus.posY      = posy_q;
    assign bus.wr_enable = wr_q;
    assign bus.r_out     = rgb_q[23:16];
    assign bus.g_out     = rgb_q[15:8];
    assign bus.b_out     = rgb_q[7:0];

endmodule

// File: tb/tb_grid_paint_ctrl.sv
// Scoreboard bench for grid_paint_ctrl: directed commands push expected writes/errors,
// an independent monitor pops and compares whenever the controller writes or flags err.
module tb_grid_paint_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    grid_paint_ctrl_if bus ();

    grid_paint_ctrl #(.GRID_W(8), .GRID_H(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          is_err;
        logic [3:0]  x;
        logic [3:0]  y;
        logic [23:0] rgb;
        bit          last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   busy_cnt = 0;
    bit   mon_en   = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void push_w(input logic [3:0] x, input logic [3:0] y,
                                   input logic [23:0] rgb, input bit last);
        exp_t e;
        e.is_err = 1'b0; e.x = x; e.y = y; e.rgb = rgb; e.last = last;
        exp_q.push_back(e);
    endfunction

    function automatic void push_e();
        exp_t e;
        e.is_err = 1'b1; e.x = 4'd0; e.y = 4'd0; e.rgb = 24'd0; e.last = 1'b0;
        exp_q.push_back(e);
    endfunction

    // Monitor: compares every presented write or error against the head of the queue
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.busy) busy_cnt++;
            chk("busy_eq_wr", {31'd0, bus.busy}, {31'd0, bus.wr_enable});
            if (bus.wr_enable || bus.err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {30'd0, bus.wr_enable, bus.err}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("kind_err", {31'd0, bus.err}, {31'd0, e.is_err});
                    if (e.is_err) begin
                        chk("err_no_write", {31'd0, bus.wr_enable}, 32'd0);
                    end else begin
                        chk("posX", {28'd0, bus.posX}, {28'd0, e.x});
                        chk("posY", {28'd0, bus.posY}, {28'd0, e.y});
                        chk("rgb", {8'd0, bus.r_out, bus.g_out, bus.b_out}, {8'd0, e.rgb});
                        chk("done", {31'd0, bus.done}, {31'd0, e.last});
                    end
                end
            end else if (bus.done) begin
                chk("done_without_write", {31'd0, bus.done}, 32'd0);
            end
        end
    end

    task automatic send(input logic [1:0] cmd, input logic [3:0] x, input logic [3:0] y,
                        input logic [2:0] c);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_cmd   = cmd;
        bus.req_x     = x;
        bus.req_y     = y;
        bus.req_color = c;
        n = 0;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("send_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic drop();
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && bus.req_ready && !bus.wr_enable) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_cmd   = 2'b00;
        bus.req_x     = 4'd0;
        bus.req_y     = 4'd0;
        bus.req_color = 3'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_wr", {31'd0, bus.wr_enable}, 32'd0);
        chk("rst_pos", {24'd0, bus.posX, bus.posY}, 32'd0);
        chk("rst_rgb", {8'd0, bus.r_out, bus.g_out, bus.b_out}, 32'd0);
        chk("rst_flags", {29'd0, bus.busy, bus.done, bus.err}, 32'd0);

        // Single paint, ready returns two cycles after acceptance
        push_w(4'd3, 4'd5, 24'hE03030, 1'b1);
        send(2'b00, 4'd3, 4'd5, 3'd3);
        drop();
        chk("paint_ready_c1", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        chk("paint_ready_c2", {31'd0, bus.req_ready}, 32'd1);
        drain("paint_drain");

        // Fill row 2, busy exactly eight cycles
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) push_w(4'(i), 4'd2, 24'h3060E0, i == 7);
        send(2'b10, 4'd0, 4'd2, 3'd5);
        drop();
        drain("row_drain");
        chk("row_busy_cycles", busy_cnt, 32'd8);

        // Clear ignores colour 6 and sweeps row-major in background colour
        busy_cnt = 0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                push_w(4'(x), 4'(y), 24'h53565B, (x == 7) && (y == 7));
        send(2'b01, 4'd2, 4'd3, 3'd6);
        drop();
        drain("clear_drain");
        chk("clear_busy_cycles", busy_cnt, 32'd64);

        // Rejections: paint x=8, paint y=8, row y=9, column x=15
        push_e();
        send(2'b00, 4'd8, 4'd0, 3'd1);
        drop();
        chk("rej_ready", {31'd0, bus.req_ready}, 32'd1);
        push_e();
        send(2'b00, 4'd0, 4'd8, 3'd1);
        drop();
        push_e();
        send(2'b10, 4'd0, 4'd9, 3'd1);
        drop();
        push_e();
        send(2'b11, 4'd15, 4'd0, 3'd1);
        drop();
        drain("reject_drain");

        // Row ignores an out-of-range x; paint at the far corner is legal
        for (int i = 0; i < 8; i++) push_w(4'(i), 4'd0, 24'hFFFFFF, i == 7);
        send(2'b10, 4'd12, 4'd0, 3'd1);
        drop();
        push_w(4'd7, 4'd7, 24'hD9D9D6, 1'b1);
        send(2'b00, 4'd7, 4'd7, 3'd7);
        drop();
        drain("edge_drain");

        // Back-to-back paints with valid held through busy
        push_w(4'd0, 4'd0, 24'h000000, 1'b1);
        push_w(4'd1, 4'd1, 24'h30C040, 1'b1);
        send(2'b00, 4'd0, 4'd0, 3'd2);
        send(2'b00, 4'd1, 4'd1, 3'd4);
        drop();
        drain("b2b_drain");

        // Column 4 aborted by reset after its third write
        for (int i = 0; i < 3; i++) push_w(4'd4, 4'(i), 24'h30C040, 1'b0);
        send(2'b11, 4'd4, 4'd0, 3'd4);
        drop();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_wr", {31'd0, bus.wr_enable}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_pos", {24'd0, bus.posX, bus.posY}, 32'd0);
        chk("abort_rgb", {8'd0, bus.r_out, bus.g_out, bus.b_out}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_4th", {31'd0, bus.wr_enable}, 32'd0);
        chk("abort_queue", exp_q.size(), 32'd0);
        chk("abort_ready", {31'd0, bus.req_ready}, 32'd1);

        push_w(4'd6, 4'd1, 24'hF0D020, 1'b1);
        send(2'b00, 4'd6, 4'd1, 3'd6);
        drop();
        drain("recover_drain");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
